// File: rtl/board_count_master_if.sv
// board_count_master_if: Wishbone bus between the
// neighbour-count initiator and the board memory.
interface board_count_master_if;
  logic       CYC_O;
  logic       STB_O;
  logic       WE_O;
  logic [7:0] ADR_O;
  logic [7:0] DAT_O;
  logic [7:0] DAT_I;
  logic       ACK_I;

  modport master (
    output CYC_O, STB_O, WE_O, ADR_O, DAT_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  CYC_O, STB_O, WE_O, ADR_O, DAT_O,
    output DAT_I, ACK_I
  );
endinterface

// File: rtl/board_count_master.sv
// board_count_master: sweeps the active NxN board and
// writes each cell's neighbour mine count into mine_ind.
module board_count_master #(
  parameter int TIMEOUT = 16
) (
  input  logic                 CLK_I,
  input  logic                 RST_NI,
  input  logic                 start_i,
  input  logic [4:0]           size_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  board_count_master_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, NBR_REQ, RD_REQ, WR_REQ, GAP, FIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  state_t        r_prev;
  logic [4:0]    r_size;
  logic [3:0]    r_row;
  logic [3:0]    r_col;
  logic [3:0]    r_nidx;
  logic [3:0]    r_cnt;
  logic [7:0]    r_rd;
  logic [TW-1:0] r_to;
  logic          r_err;

  logic       w_legal;
  logic       w_stb;
  logic       w_ack;
  logic       w_timeout;
  logic       w_last_col;
  logic       w_last;
  logic       w_err;
  logic [3:0] w_nrow;
  logic [3:0] w_ncol;
  logic [3:0] w_find_st;
  logic [3:0] w_find_nx;
  logic [3:0] w_find_cell;

  function automatic logic [3:0] f_dr(input logic [2:0] k);
    case (k)
      3'd0, 3'd1, 3'd2: f_dr = 4'hF;
      3'd3, 3'd4:       f_dr = 4'h0;
      default:          f_dr = 4'h1;
    endcase
  endfunction

  function automatic logic [3:0] f_dc(input logic [2:0] k);
    case (k)
      3'd0, 3'd3, 3'd5: f_dc = 4'hF;
      3'd1, 3'd6:       f_dc = 4'h0;
      default:          f_dc = 4'h1;
    endcase
  endfunction

  // A negative coordinate wraps to a large unsigned value,
  // so a single "< N" test rejects both edges.
  function automatic logic f_ok(
    input logic [3:0] row,
    input logic [3:0] col,
    input logic [4:0] n,
    input logic [2:0] k
  );
    logic [3:0] v_dr;
    logic [3:0] v_dc;
    logic [5:0] v_r;
    logic [5:0] v_c;
    v_dr = f_dr(k);
    v_dc = f_dc(k);
    v_r  = {2'b00, row} + {{2{v_dr[3]}}, v_dr};
    v_c  = {2'b00, col} + {{2{v_dc[3]}}, v_dc};
    return (v_r < {1'b0, n}) && (v_c < {1'b0, n});
  endfunction

  // First in-range neighbour index >= from; 8 when none.
  function automatic logic [3:0] f_find(
    input logic [3:0] row,
    input logic [3:0] col,
    input logic [4:0] n,
    input logic [3:0] from
  );
    logic [3:0] v_k;
    v_k = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (4'(i) >= from && f_ok(row, col, n, 3'(i)))
        v_k = 4'(i);
    end
    return v_k;
  endfunction

  assign w_legal = (size_i != 5'd0) && (size_i <= 5'd16);
  assign w_stb = (r_state == NBR_REQ) ||
                 (r_state == RD_REQ) ||
                 (r_state == WR_REQ);
  assign w_ack = w_stb && bus.ACK_I;
  assign w_timeout = w_stb && !bus.ACK_I &&
                     (r_to == TW'(TIMEOUT - 1));
  assign w_last_col = ({1'b0, r_col} == r_size - 5'd1);
  assign w_last = w_last_col &&
                  ({1'b0, r_row} == r_size - 5'd1);
  assign w_ncol = w_last_col ? 4'd0 : r_col + 4'd1;
  assign w_nrow = w_last_col ? r_row + 4'd1 : r_row;

  assign w_find_st = f_find(4'd0, 4'd0, size_i, 4'd0);
  assign w_find_nx = f_find(r_row, r_col, r_size,
                            r_nidx + 4'd1);
  assign w_find_cell = f_find(w_nrow, w_ncol, r_size, 4'd0);

  // State register.
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) r_state <= IDLE;
    else         r_state <= w_state_nx;
  end

  // Next-state and error pulse decode.
  always_comb begin
    w_state_nx = r_state;
    w_err      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          if (!w_legal)          w_err = 1'b1;
          else if (w_find_st[3]) w_state_nx = RD_REQ;
          else                   w_state_nx = NBR_REQ;
        end
      end
      NBR_REQ, RD_REQ, WR_REQ: begin
        if (w_ack) begin
          w_state_nx = GAP;
        end else if (w_timeout) begin
          w_state_nx = IDLE;
          w_err      = 1'b1;
        end
      end
      GAP: begin
        case (r_prev)
          NBR_REQ:
            w_state_nx = w_find_nx[3] ? RD_REQ : NBR_REQ;
          RD_REQ:
            w_state_nx = WR_REQ;
          default: begin
            if (w_last)              w_state_nx = FIN;
            else if (w_find_cell[3]) w_state_nx = RD_REQ;
            else                     w_state_nx = NBR_REQ;
          end
        endcase
      end
      FIN:     w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Sweep position, neighbour count and captured cell data.
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      r_prev <= IDLE;
      r_size <= 5'd0;
      r_row  <= 4'd0;
      r_col  <= 4'd0;
      r_nidx <= 4'd0;
      r_cnt  <= 4'd0;
      r_rd   <= 8'd0;
      r_to   <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_stb && !bus.ACK_I) r_to <= r_to + 1'b1;
      else                     r_to <= '0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_size <= size_i;
            r_row  <= 4'd0;
            r_col  <= 4'd0;
            r_cnt  <= 4'd0;
            r_nidx <= w_find_st;
          end
        end
        NBR_REQ: begin
          if (bus.ACK_I) begin
            r_cnt  <= r_cnt + {3'b000, bus.DAT_I[7]};
            r_prev <= NBR_REQ;
          end
        end
        RD_REQ: begin
          if (bus.ACK_I) begin
            r_rd   <= bus.DAT_I & 8'hE1;
            r_prev <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (bus.ACK_I) r_prev <= WR_REQ;
        end
        GAP: begin
          if (r_prev == NBR_REQ) begin
            r_nidx <= w_find_nx;
          end else if (r_prev == WR_REQ) begin
            r_row  <= w_nrow;
            r_col  <= w_ncol;
            r_cnt  <= 4'd0;
            r_nidx <= w_find_cell;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.CYC_O = w_stb;
  assign bus.STB_O = w_stb;
  assign bus.WE_O  = (r_state == WR_REQ);
  assign bus.ADR_O = (r_state == NBR_REQ) ?
    {r_row + f_dr(r_nidx[2:0]), r_col + f_dc(r_nidx[2:0])} :
    {r_row, r_col};
  assign bus.DAT_O = r_rd | {3'b000, r_cnt, 1'b0};

  assign busy_o = w_stb || (r_state == GAP);
  assign done_o = (r_state == FIN);
  assign err_o  = r_err;
endmodule

// File: doc/board_count_master.md
Name: board_count_master

Overview:
- Wishbone initiator that fills the per-cell neighbour mine count (mine_ind) of the 16x16 board memory after mine placement.
- Sweeps the active NxN area in row-major order. For each cell it reads the in-bounds neighbours, then does a read-modify-write of the cell itself, preserving every bit except mine_ind.
- Sits between the game controller (start/done) and the board memory Wishbone responder.

Parameters:
- TIMEOUT, 16, max cycles STB_O may stay high without ACK_I before the sweep aborts with err_o.

Ports:
- CLK_I  in  1  clock
- RST_NI  in  1  synchronous active-low reset
- start_i  in  1  one-cycle pulse; begins a sweep when idle
- size_i  in  5  active board edge N, legal 1..16; latched at start
- busy_o  out  1  high from the cycle after an accepted start until done/err
- done_o  out  1  one-cycle pulse on sweep completion
- err_o  out  1  one-cycle pulse on illegal size or ACK timeout
- CYC_O  out  1  Wishbone cycle
- STB_O  out  1  Wishbone strobe
- WE_O  out  1  1 = write
- ADR_O  out  8  {row[3:0], col[3:0]}
- DAT_O  out  8  write data
- DAT_I  in  8  read data
- ACK_I  in  1  responder acknowledge

Behaviour:
- Field byte: [7] mine, [6] flag, [5] defused, [4:1] mine_ind, [0] reserved.
- Reset: all outputs 0; FSM to IDLE; counters cleared. Takes effect at the next edge, even mid-transaction; the pending access is abandoned.
- FSM states: IDLE, NBR_REQ, RD_REQ, WR_REQ, GAP, FIN.
- IDLE: start_i=1 latches size_i.
  - size 0 or >16: err_o=1 the next cycle; no bus activity; stay IDLE.
  - Otherwise: busy_o=1, cell=(0,0), cnt=0, go to the first request.
- start_i while busy_o=1 is ignored.
- Transaction: STB_O=CYC_O=1 with ADR_O/WE_O/DAT_O stable until ACK_I is sampled high.
  - STB_O and CYC_O drop at that edge; read data is captured from DAT_I in the ACK cycle.
  - GAP follows: exactly one cycle with STB_O=0.
  - ACK_I is ignored whenever STB_O=0. The responder re-acks a strobe held into the ACK cycle.
- Timing: with a 1-cycle responder, each transaction costs 3 cycles (req, ack, gap).
- Neighbour order: (dr,dc) = (-1,-1),(-1,0),(-1,1),(0,-1),(0,1),(1,-1),(1,0),(1,1).
  - Out-of-range neighbours (row/col <0 or >=N) are skipped with zero cycles spent.
  - On each neighbour ACK: cnt += DAT_I[7]. cnt is 4 bits, max 8, no overflow.
- After the last valid neighbour: RD_REQ reads the cell, then WR_REQ writes DAT_O = {rd[7:5], cnt[3:0], rd[0]}.
  - The cell's own mine bit does not affect its count.
- After the write's GAP, advance: col+1, wrapping to 0 with row+1 at col=N-1; cnt cleared.
  - After cell (N-1,N-1): FIN asserts done_o for one cycle, busy_o drops in the same cycle, then IDLE.
- Timing from start (start sampled in cycle 0, T transactions, 1-cycle responder):
  - First STB_O in cycle 1.
  - done_o in cycle 3T+1.
  - T = 4(N-1)(2N-1) + 2N².
- Timeout: STB_O high for TIMEOUT consecutive cycles without ACK_I. Then:
  - Next cycle: STB_O=CYC_O=0, err_o=1 for one cycle, busy_o=0, IDLE.
  - No done_o; already-written cells stay written.
- N=1: no neighbours; read plus write of (0,0) with cnt=0.

Test Plan:
- N=2, all four cells preloaded 0x80: 20 transactions; every cell reads back 0x86; done_o in cycle 61; busy_o high cycles 1..60.
- N=3, preload (1,1)=0x80, (0,0)=0x40, others 0x00:
  - Result: (0,0)=0x42, (1,1)=0x80, every other cell in the 3x3 area=0x02.
  - Cells outside 3x3 are never addressed.
- N=16, all cells 0x80:
  - Interior cell 0x90, edge cell 0x8A, corner cell 0x86.
  - T=2372; done_o in cycle 7117.
- Responder holds ACK_I=0 from the first request: err_o pulses after 16 STB_O-high cycles; CYC_O=STB_O=0 afterwards; done_o never asserts.
- size_i=0 and size_i=17: err_o pulse one cycle after start, CYC_O stays 0. start_i pulsed mid-sweep of N=2: no effect, same 61-cycle result.
- RST_NI=0 for one cycle during a WR_REQ: all outputs 0 at the next edge. A fresh start then completes the sweep normally.
